distributor: RTL

- QSPI-side inbound block, the opposite direction to the encrypter collector path.
- Accepts a 4-bit nibble stream from the QSPI link and assembles each `ENCRYPTER_WIDTH`-bit packet, least-significant nibble first.
- Dispatches each completed packet to the encrypters in strict round-robin order (0,1,…,N-1,0,…). Packet order on the link therefore maps deterministically onto encrypters.
- Sits between the QSPI slave interface and the encrypter array inputs.

---
 rtl/distributor_pkg.sv | 20 ++
 rtl/distributor_if.sv | 30 +++
 rtl/distributor_nibble_assembler.sv | 46 ++++
 rtl/distributor.sv | 78 +++++++
 4 files changed

// File: rtl/distributor_pkg.sv
// Shared constants and types for the QSPI inbound distributor.
// Packet geometry, register widths and the dispatch state encoding.
package distributor_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ENCRYPTER_WIDTH          = 64;
  localparam int NUM_ENCRYPTERS           = 4;
  localparam int ENCRYPTER_QSPI_COUNT     = ENCRYPTER_WIDTH / 4;
  localparam int ENCRYPTER_QSPI_COUNT_REG = $clog2(ENCRYPTER_QSPI_COUNT);
  localparam int NUM_ENCRYPTERS_REG       = idx_width(NUM_ENCRYPTERS);

  typedef enum logic {
    RECEIVE  = 1'b0,
    DISPATCH = 1'b1
  } dist_state_e;

endpackage

// File: rtl/distributor_if.sv
// QSPI nibble link plus the shared encrypter load bus.
// master = link sender and encrypter array, slave = distributor.
interface distributor_if #(
  parameter int ENCRYPTER_WIDTH = distributor_pkg::ENCRYPTER_WIDTH,
  parameter int NUM_ENCRYPTERS  = distributor_pkg::NUM_ENCRYPTERS
);
  import distributor_pkg::*;
  localparam int IW = idx_width(NUM_ENCRYPTERS);

  logic [3:0]                 qspi_data;
  logic                       qspi_valid;
  logic                       qspi_cs;
  logic                       qspi_ready;
  logic                       frame_error;
  logic [ENCRYPTER_WIDTH-1:0] enc_data;
  logic [NUM_ENCRYPTERS-1:0]  enc_load;
  logic [NUM_ENCRYPTERS-1:0]  enc_ready;
  logic [IW-1:0]              enc_index;

  modport master (
    output qspi_data, qspi_valid, qspi_cs, enc_ready,
    input  qspi_ready, frame_error, enc_data, enc_load, enc_index
  );

  modport slave (
    input  qspi_data, qspi_valid, qspi_cs, enc_ready,
    output qspi_ready, frame_error, enc_data, enc_load, enc_index
  );

endinterface

// File: rtl/distributor_nibble_assembler.sv
// Collects nibbles LSN-first into a packet; flags completion and mid-packet aborts.
// The final nibble bypasses the shift register so the packet is whole on the done cycle.
module distributor_nibble_assembler #(
  parameter int PKT_WIDTH = distributor_pkg::ENCRYPTER_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           nib_i,
  input  logic                 valid_i,
  input  logic                 cs_i,
  input  logic                 active_i,
  output logic [PKT_WIDTH-1:0] packet_o,
  output logic                 done_o,
  output logic                 abort_o
);
  localparam int NIB = PKT_WIDTH / 4;
  localparam int CW  = $clog2(NIB);

  logic [CW-1:0]        count_q;
  logic [PKT_WIDTH-5:0] shreg_q;
  logic                 accept;
  logic                 last;

  assign accept   = active_i & cs_i & valid_i;
  assign last     = (count_q == CW'(NIB - 1));
  assign done_o   = accept & last;
  assign abort_o  = active_i & ~cs_i & (count_q != '0);
  assign packet_o = {nib_i, shreg_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      shreg_q <= '0;
    end else if (abort_o) begin
      count_q <= '0;
    end else if (accept) begin
      if (last) begin
        count_q <= '0;
      end else begin
        count_q                    <= count_q + 1'b1;
        shreg_q[{count_q, 2'b00} +: 4] <= nib_i;
      end
    end
  end

endmodule

// File: rtl/distributor.sv
// QSPI inbound distributor: assembles packets and hands each to the next encrypter in
// strict round-robin order, stalling on the current target rather than skipping it.
module distributor #(
  parameter int ENCRYPTER_WIDTH = distributor_pkg::ENCRYPTER_WIDTH,
  parameter int NUM_ENCRYPTERS  = distributor_pkg::NUM_ENCRYPTERS
) (
  input logic          clk,
  input logic          reset,
  distributor_if.slave bus
);
  import distributor_pkg::*;
  localparam int IW = idx_width(NUM_ENCRYPTERS);

  dist_state_e                state_q;
  logic [IW-1:0]              index_q;
  logic [IW-1:0]              index_d;
  logic [ENCRYPTER_WIDTH-1:0] enc_data_q;
  logic [ENCRYPTER_WIDTH-1:0] packet;
  logic [NUM_ENCRYPTERS-1:0]  enc_load_q;
  logic                       frame_error_q;
  logic                       receiving;
  logic                       done;
  logic                       abort;

  assign receiving = (state_q == RECEIVE);
  assign index_d   = (index_q == IW'(NUM_ENCRYPTERS - 1)) ? '0 : index_q + 1'b1;

  distributor_nibble_assembler #(
    .PKT_WIDTH (ENCRYPTER_WIDTH)
  ) u_asm (
    .clk      (clk),
    .reset    (reset),
    .nib_i    (bus.qspi_data),
    .valid_i  (bus.qspi_valid),
    .cs_i     (bus.qspi_cs),
    .active_i (receiving),
    .packet_o (packet),
    .done_o   (done),
    .abort_o  (abort)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RECEIVE;
      index_q       <= '0;
      enc_data_q    <= '0;
      enc_load_q    <= '0;
      frame_error_q <= 1'b0;
    end else begin
      enc_load_q    <= '0;
      frame_error_q <= abort;
      case (state_q)
        RECEIVE: begin
          if (done) begin
            enc_data_q <= packet;
            state_q    <= DISPATCH;
          end
        end
        DISPATCH: begin
          // Wait on the current target only; skipping would break the packet-to-encrypter mapping.
          if (bus.enc_ready[index_q]) begin
            enc_load_q[index_q] <= 1'b1;
            index_q             <= index_d;
            state_q             <= RECEIVE;
          end
        end
        default: state_q <= RECEIVE;
      endcase
    end
  end

  assign bus.qspi_ready  = receiving;
  assign bus.frame_error = frame_error_q;
  assign bus.enc_data    = enc_data_q;
  assign bus.enc_load    = enc_load_q;
  assign bus.enc_index   = index_q;

endmodule
